// File: rtl/imem_prefetch_if.sv
// imem_prefetch_if: redirect, program-load and instruction-stream signals of the prefetcher
interface imem_prefetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              instr_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_fault;
    modport master (
        output redirect, redirect_pc, load_en, load_addr, load_data, instr_ready,
        input  instr_valid, instr, instr_pc, instr_fault
    );
    modport slave (
        input  redirect, redirect_pc, load_en, load_addr, load_data, instr_ready,
        output instr_valid, instr, instr_pc, instr_fault
    );
endinterface

// File: rtl/imem_prefetch.sv
// imem_prefetch: instruction memory with a run/halt fetcher feeding a small prefetch FIFO
module imem_prefetch #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 256,
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input logic           clk,
    input logic           reset,
    imem_prefetch_if.slave bus
);
    localparam int WA = $clog2(DEPTH);
    localparam int FA = $clog2(FIFO_DEPTH);
    typedef enum logic {RUN, HALT} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;
    logic              inf_v, inf_fault;
    logic [ADDR_W-1:0] inf_pc;
    logic [DATA_W-1:0] f_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] f_pc [FIFO_DEPTH];
    logic              f_fault [FIFO_DEPTH];
    logic [FA-1:0]     rd_ptr, wr_ptr;
    logic [FA:0]       count;
    logic              bad, issue, push, pop, ld_ok;
    // occupancy counts the in-flight read so the FIFO can never overflow
    always_comb begin
        bad      = pc[1:0] != 2'b00 || (pc >> 2) >= ADDR_W'(DEPTH);
        issue    = state == RUN && !bus.redirect && (32'(count) + 32'(inf_v)) < 32'(FIFO_DEPTH);
        push     = inf_v && !bus.redirect;
        pop      = count != 0 && bus.instr_ready && !bus.redirect;
        ld_ok    = bus.load_en && !reset && bus.load_addr[1:0] == 2'b00 && (bus.load_addr >> 2) < ADDR_W'(DEPTH);
        state_nx = bus.redirect ? RUN : (issue && bad) ? HALT : state;
        pc_nx    = bus.redirect ? bus.redirect_pc : (issue && !bad) ? pc + ADDR_W'(4) : pc;
    end
    always_ff @(posedge clk) begin
        if (ld_ok) mem[bus.load_addr[WA+1:2]] <= bus.load_data;
        if (issue && !bad && !reset) rdata <= mem[pc[WA+1:2]];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            inf_v     <= 1'b0;
            inf_fault <= 1'b0;
            inf_pc    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            inf_v     <= issue;
            inf_fault <= bad;
            inf_pc    <= pc;
            rd_ptr    <= bus.redirect ? '0 : rd_ptr + FA'(pop);
            wr_ptr    <= bus.redirect ? '0 : wr_ptr + FA'(push);
            count     <= bus.redirect ? '0 : count + (FA+1)'(push) - (FA+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            f_data[wr_ptr]  <= inf_fault ? '0 : rdata;
            f_pc[wr_ptr]    <= inf_pc;
            f_fault[wr_ptr] <= inf_fault;
        end
    end
    assign bus.instr_valid = count != 0;
    assign bus.instr       = bus.instr_valid ? f_data[rd_ptr] : '0;
    assign bus.instr_pc    = bus.instr_valid ? f_pc[rd_ptr] : '0;
    assign bus.instr_fault = bus.instr_valid && f_fault[rd_ptr];
endmodule

// File: tb/tb_imem_prefetch.sv
// tb_imem_prefetch: queue-based reference model plus directed scenarios for imem_prefetch
module tb_imem_prefetch;
    typedef struct {
        logic [31:0] d;
        logic [31:0] p;
        logic        f;
    } ent_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   check_en = 0;
    imem_prefetch_if #(.DATA_W(32), .ADDR_W(32)) bus();
    imem_prefetch #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    ent_t        q[$];
    ent_t        pe;
    bit          pv;
    bit          halt;
    logic [31:0] mpc;
    logic [31:0] mm [256];
    int          occ;
    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endfunction
    // expected stream: fetch queue limited to 4 outstanding words, faults halt the fetcher
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            pv = 0;
            mpc = 32'h0;
            halt = 0;
        end else if (bus.redirect) begin
            q.delete();
            pv = 0;
            mpc = bus.redirect_pc;
            halt = 0;
        end else begin
            occ = q.size() + int'(pv);
            if (q.size() != 0 && bus.instr_ready) void'(q.pop_front());
            if (pv) q.push_back(pe);
            pv = !halt && occ < 4;
            if (pv) begin
                if (mpc[1:0] != 2'b00 || mpc >= 32'h400) begin
                    pe = '{32'h0, mpc, 1'b1};
                    halt = 1;
                end else begin
                    pe = '{mm[mpc[9:2]], mpc, 1'b0};
                    mpc = mpc + 32'd4;
                end
            end
        end
        if (!reset && bus.load_en && bus.load_addr[1:0] == 2'b00 && bus.load_addr < 32'h400)
            mm[bus.load_addr[9:2]] = bus.load_data;
    end
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_instr", bus.instr, q[0].d);
                chk("m_pc", bus.instr_pc, q[0].p);
                chk("m_fault", 32'(bus.instr_fault), 32'(q[0].f));
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic redir(input logic [31:0] a);
        bus.redirect = 1'b1;
        bus.redirect_pc = a;
        tick;
        bus.redirect = 1'b0;
    endtask
    initial begin
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.load_en = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.instr_ready = 1'b0;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.load_en = 1'b1;
            bus.load_addr = 32'(i * 4);
            bus.load_data = 32'h1000_0000 + 32'(i);
            tick;
        end
        bus.load_addr = 32'h2;
        bus.load_data = 32'hDEAD_0002;
        tick;
        bus.load_addr = 32'h400;
        bus.load_data = 32'hDEAD_0400;
        tick;
        bus.load_en = 1'b0;
        // reset values, then one word per cycle from the second edge
        reset = 1'b1;
        bus.instr_ready = 1'b1;
        tick;
        check_en = 1;
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_fault", 32'(bus.instr_fault), 32'h0);
        reset = 1'b0;
        tick;
        chk("a_valid_edge1", 32'(bus.instr_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("a_valid", 32'(bus.instr_valid), 32'h1);
            chk("a_pc", bus.instr_pc, 32'(i * 4));
            chk("a_instr", bus.instr, 32'h1000_0000 + 32'(i));
        end
        // stalled consumer: buffer saturates on the first word
        reset = 1'b1;
        bus.instr_ready = 1'b0;
        tick;
        reset = 1'b0;
        repeat (10) tick;
        chk("b_valid", 32'(bus.instr_valid), 32'h1);
        chk("b_hold_pc", bus.instr_pc, 32'h0);
        chk("b_hold_instr", bus.instr, 32'h1000_0000);
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk("b_pc", bus.instr_pc, 32'(k * 4));
        end
        // redirect while full, with ready high on the redirect edge
        bus.instr_ready = 1'b0;
        repeat (6) tick;
        bus.instr_ready = 1'b1;
        redir(32'h14);
        bus.instr_ready = 1'b0;
        chk("c_valid_r0", 32'(bus.instr_valid), 32'h0);
        tick;
        chk("c_valid_r1", 32'(bus.instr_valid), 32'h0);
        tick;
        chk("c_valid_r2", 32'(bus.instr_valid), 32'h1);
        chk("c_pc", bus.instr_pc, 32'h14);
        chk("c_instr", bus.instr, 32'h1000_0005);
        // misaligned redirect yields one fault entry and halts
        redir(32'h6);
        repeat (2) tick;
        chk("d_valid", 32'(bus.instr_valid), 32'h1);
        chk("d_fault", 32'(bus.instr_fault), 32'h1);
        chk("d_pc", bus.instr_pc, 32'h6);
        chk("d_instr", bus.instr, 32'h0);
        bus.instr_ready = 1'b1;
        tick;
        chk("d_popped", 32'(bus.instr_valid), 32'h0);
        repeat (3) tick;
        chk("d_halted", 32'(bus.instr_valid), 32'h0);
        redir(32'h0);
        repeat (2) tick;
        chk("d_resume_pc", bus.instr_pc, 32'h0);
        chk("d_resume_fault", 32'(bus.instr_fault), 32'h0);
        // end of memory: last word valid, next address faults
        redir(32'h3F0);
        repeat (5) tick;
        chk("e_last_pc", bus.instr_pc, 32'h3FC);
        chk("e_last_instr", bus.instr, 32'h1000_00FF);
        chk("e_last_fault", 32'(bus.instr_fault), 32'h0);
        tick;
        chk("e_oor_pc", bus.instr_pc, 32'h400);
        chk("e_oor_fault", 32'(bus.instr_fault), 32'h1);
        chk("e_oor_instr", bus.instr, 32'h0);
        repeat (3) begin
            tick;
            chk("e_halt", 32'(bus.instr_valid), 32'h0);
        end
        // load and fetch of the same word on one edge returns the old word
        bus.instr_ready = 1'b0;
        redir(32'h0);
        bus.load_en = 1'b1;
        bus.load_addr = 32'h0;
        bus.load_data = 32'hAAAA_0000;
        tick;
        bus.load_en = 1'b0;
        tick;
        chk("f_old", bus.instr, 32'h1000_0000);
        redir(32'h0);
        repeat (2) tick;
        chk("f_new", bus.instr, 32'hAAAA_0000);
        bus.load_en = 1'b1;
        bus.load_data = 32'h1000_0000;
        tick;
        bus.load_en = 1'b0;
        // reset beats redirect, load and ready with entries buffered
        reset = 1'b1;
        tick;
        reset = 1'b0;
        repeat (4) tick;
        chk("g_pre_valid", 32'(bus.instr_valid), 32'h1);
        reset = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h20;
        bus.load_en = 1'b1;
        bus.load_addr = 32'h4;
        bus.load_data = 32'hBBBB_0000;
        bus.instr_ready = 1'b1;
        tick;
        chk("g_valid", 32'(bus.instr_valid), 32'h0);
        chk("g_pc", bus.instr_pc, 32'h0);
        reset = 1'b0;
        bus.redirect = 1'b0;
        bus.load_en = 1'b0;
        repeat (2) tick;
        chk("g_restart_pc", bus.instr_pc, 32'h0);
        chk("g_restart_instr", bus.instr, 32'h1000_0000);
        tick;
        chk("g_next_pc", bus.instr_pc, 32'h4);
        chk("g_next_instr", bus.instr, 32'h1000_0001);
        tick;
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
